// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding,
// counter width, inactive grant pattern and the rotating priority pick.
package rr_arbiter_4_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGrant = 2'b01,
    StGap   = 2'b10
  } state_e;

  localparam int unsigned HOLD_W     = 8;
  localparam logic [3:0]  GNT_NONE_L = 4'b1111;

  // First active-high request in the order last+1, last+2, last+3, last (mod 4).
  // Scanning from the lowest priority upwards lets the last hit win.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dec2to4_l.sv
// 2-to-4 decoder with active-low enable and active-low one-hot outputs.
module dec2to4_l
  import rr_arbiter_4_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       en_l,
  output logic [3:0] y_l
);

  always_comb begin
    y_l = GNT_NONE_L;
    if (!en_l) begin
      y_l[sel] = 1'b0;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with active-low requests/grants, a bounded hold
// time under contention and one dead cycle between consecutive grants.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic [3:0] REQ_L,
  output logic [3:0] GNT_L,
  output logic [1:0] GNT_IDX,
  output logic       BUSY
);

  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q;
  logic [1:0]        gnt_idx_q;
  logic [1:0]        last_q;
  logic [HOLD_W-1:0] hold_q;
  logic              busy_q;

  logic [3:0] req;
  logic       req_any;
  logic [1:0] pick;
  logic [3:0] others;
  logic       gnt_en_l;

  assign req     = ~REQ_L;
  assign req_any = |req;
  assign pick    = rr_pick(req, last_q);
  assign others  = req & ~(4'b0001 << gnt_idx_q);

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= StIdle;
      gnt_idx_q <= 2'b00;
      last_q    <= 2'b11;
      hold_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StGap: begin
          if (req_any) begin
            state_q   <= StGrant;
            gnt_idx_q <= pick;
            last_q    <= pick;
            hold_q    <= '0;
            busy_q    <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StGrant: begin
          if (!req[gnt_idx_q]) begin
            state_q <= StGap;
            busy_q  <= 1'b0;
          end else if (hold_q == HoldMax && |others) begin
            state_q <= StGap;
            busy_q  <= 1'b0;
          end else if (hold_q != HoldMax) begin
            // Saturating so a lone holder keeps the grant indefinitely.
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_en_l = ~busy_q;

  dec2to4_l u_dec (
    .sel  (gnt_idx_q),
    .en_l (gnt_en_l),
    .y_l  (GNT_L)
  );

  assign GNT_IDX = gnt_idx_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed and randomized checks for rr_arbiter_4 with MAX_HOLD = 4.
module tb_rr_arbiter_4;

  localparam int unsigned MaxHold = 4;
  localparam int          WaitLimit = 4 * (MaxHold + 1);

  logic       CLK;
  logic       RESET_L;
  logic [3:0] REQ_L;
  logic [3:0] GNT_L;
  logic [1:0] GNT_IDX;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req_l;
    logic [3:0] gnt_l;
    logic [1:0] idx;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter_4 #(.MAX_HOLD(MaxHold)) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .REQ_L   (REQ_L),
    .GNT_L   (GNT_L),
    .GNT_IDX (GNT_IDX),
    .BUSY    (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i,
                              input logic b);
    vec_t v;
    v.req_l = r;
    v.gnt_l = g;
    v.idx   = i;
    v.busy  = b;
    return v;
  endfunction

  initial begin
    logic [3:0] prev_gnt;
    logic [3:0] flip;
    int         wait_cnt [4];

    // Rotation 0,1,2,3,0 with each holder releasing after three grant cycles.
    vecs.push_back(mk(4'b0000, 4'b1110, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b1110, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b1110, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b1111, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1101, 2'd1, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b1101, 2'd1, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b1101, 2'd1, 1'b1));
    vecs.push_back(mk(4'b0010, 4'b1111, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1011, 2'd2, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b1011, 2'd2, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b1011, 2'd2, 1'b1));
    vecs.push_back(mk(4'b0100, 4'b1111, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0111, 2'd3, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0111, 2'd3, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0111, 2'd3, 1'b1));
    vecs.push_back(mk(4'b1000, 4'b1111, 2'd3, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1110, 2'd0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b1111, 2'd0, 1'b0));
    // Requester 2 alone for 10 cycles; counter saturates, grant held.
    for (int i = 0; i < 10; i++) vecs.push_back(mk(4'b1011, 4'b1011, 2'd2, 1'b1));
    // Contest against a saturated counter preempts at the first sampled edge.
    vecs.push_back(mk(4'b1010, 4'b1111, 2'd2, 1'b0));
    vecs.push_back(mk(4'b1010, 4'b1110, 2'd0, 1'b1));
    // Fresh contested grant lasts exactly MAX_HOLD cycles.
    vecs.push_back(mk(4'b1010, 4'b1110, 2'd0, 1'b1));
    vecs.push_back(mk(4'b1010, 4'b1110, 2'd0, 1'b1));
    vecs.push_back(mk(4'b1010, 4'b1110, 2'd0, 1'b1));
    vecs.push_back(mk(4'b1010, 4'b1111, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1010, 4'b1011, 2'd2, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 2'd2, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b1111, 2'd2, 1'b0));
    // Holder 3 releases while requester 1 arrives; index holds through idle.
    vecs.push_back(mk(4'b0111, 4'b0111, 2'd3, 1'b1));
    vecs.push_back(mk(4'b0111, 4'b0111, 2'd3, 1'b1));
    vecs.push_back(mk(4'b1101, 4'b1111, 2'd3, 1'b0));
    vecs.push_back(mk(4'b1101, 4'b1101, 2'd1, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 2'd1, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b1111, 2'd1, 1'b0));

    // Reset with all requests pending.
    RESET_L = 1'b0;
    REQ_L   = 4'b0000;
    tick();
    tick();
    check("reset gnt_l", 32'(GNT_L), 32'hf);
    check("reset busy", 32'(BUSY), 32'h0);
    check("reset idx", 32'(GNT_IDX), 32'h0);
    RESET_L = 1'b1;
    tick();
    check("first grant gnt_l", 32'(GNT_L), 32'he);
    check("first grant idx", 32'(GNT_IDX), 32'h0);

    // Async reset drops the grant without a clock edge.
    #2;
    RESET_L = 1'b0;
    REQ_L   = 4'b1111;
    #1;
    check("async reset gnt_l", 32'(GNT_L), 32'hf);
    tick();
    RESET_L = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      REQ_L = vecs[i].req_l;
      tick();
      check($sformatf("vec[%0d] gnt_l", i), 32'(GNT_L), 32'(vecs[i].gnt_l));
      check($sformatf("vec[%0d] idx", i), 32'(GNT_IDX), 32'(vecs[i].idx));
      check($sformatf("vec[%0d] busy", i), 32'(BUSY), 32'(vecs[i].busy));
    end

    // Lone requester 1 keeps the grant through counter saturation.
    REQ_L = 4'b1101;
    for (int i = 0; i < 300; i++) begin
      tick();
      check($sformatf("lone cyc %0d gnt_l", i), 32'(GNT_L), 32'hd);
    end

    // Hand over to requester 2, then reset mid-grant.
    REQ_L = 4'b1011;
    tick();
    check("handover gap gnt_l", 32'(GNT_L), 32'hf);
    tick();
    check("handover gnt_l", 32'(GNT_L), 32'hb);
    #2;
    RESET_L = 1'b0;
    #1;
    check("mid-grant reset gnt_l", 32'(GNT_L), 32'hf);
    check("mid-grant reset busy", 32'(BUSY), 32'h0);
    check("mid-grant reset idx", 32'(GNT_IDX), 32'h0);
    REQ_L = 4'b1010;
    #2;
    RESET_L = 1'b1;
    tick();
    check("post-reset gnt_l", 32'(GNT_L), 32'he);
    check("post-reset idx", 32'(GNT_IDX), 32'h0);

    // Random traffic: one-hot, grant only to requesters, break-before-make, bounded wait.
    REQ_L = 4'b1111;
    tick();
    tick();
    tick();
    prev_gnt = GNT_L;
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 10000; c++) begin
      flip = '0;
      for (int k = 0; k < 4; k++) flip[k] = ($urandom_range(0, 7) == 0);
      REQ_L = REQ_L ^ flip;
      tick();
      check($sformatf("rand %0d onehot", c), 32'($countones(~GNT_L) <= 1), 32'h1);
      check($sformatf("rand %0d granted w/o req", c), 32'(~GNT_L & REQ_L), 32'h0);
      check($sformatf("rand %0d break-before-make", c),
            32'(prev_gnt != 4'b1111 && GNT_L != 4'b1111 && GNT_L != prev_gnt), 32'h0);
      for (int k = 0; k < 4; k++) begin
        if (!REQ_L[k] && GNT_L[k]) wait_cnt[k]++;
        else wait_cnt[k] = 0;
      end
      check($sformatf("rand %0d wait bound", c),
            32'(wait_cnt[0] > WaitLimit || wait_cnt[1] > WaitLimit ||
                wait_cnt[2] > WaitLimit || wait_cnt[3] > WaitLimit), 32'h0);
      prev_gnt = GNT_L;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
